// File: rtl/fsm_ctrl_pkg.sv
// Shared state encoding, default geometry and hit-counter helper
// for the serial stimulus arbiter.
package fsm_ctrl_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int WORD_W_DEF = 14;
  localparam int LAT_DEF    = 1;
  localparam int HIT_W      = 4;
  localparam logic [HIT_W-1:0] HIT_MAX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Hit counter sticks at its maximum instead of wrapping.
  function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] cnt,
                                                   input logic inc);
    logic [HIT_W-1:0] res;
    if (inc && (cnt != HIT_MAX)) begin
      res = cnt + 4'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps, the first active request wins (one-hot).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] winner
);

  logic [IDX_W-1:0] idx_s;
  logic             taken_s;

  // Walk the requesters in rotated priority order; the first hit masks the rest.
  always_comb begin
    winner  = {N_REQ{1'b0}};
    idx_s   = {IDX_W{1'b0}};
    taken_s = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s         = IDX_W'((int'(last_grant) + i) % N_REQ);
      winner[idx_s] = req[idx_s] & ~taken_s;
      taken_s       = taken_s | req[idx_s];
    end
  end

endmodule

// File: rtl/serial_stim_arbiter.sv
// Grants one requester at a time, shifts its frame out LSB first to the
// detector, drains the detector latency and reports the frame's hit count.
module serial_stim_arbiter
  import fsm_ctrl_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int LAT    = LAT_DEF,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    ser_out,
  input  logic                    det_in,
  output logic                    done,
  output logic [IDX_W-1:0]        done_id,
  output logic [HIT_W-1:0]        hit_cnt
);

  localparam int CNT_W = $clog2(((WORD_W > LAT) ? WORD_W : LAT) + 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HIT_W-1:0]   hit_q, hit_d, hit_inc_s;
  logic [IDX_W-1:0]   cur_id_q, cur_id_d, last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, win_s;
  logic               busy_q, busy_d, ser_q, ser_d, done_q, done_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [IDX_W-1:0]   win_idx_s;
  logic [WORD_W-1:0]  win_data_s;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .last_grant (last_q),
    .winner     (win_s)
  );

  // One-hot winner to index and frame word.
  always_comb begin
    win_idx_s  = {IDX_W{1'b0}};
    win_data_s = {WORD_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s  = win_idx_s | (IDX_W'(i) & {IDX_W{win_s[i]}});
      win_data_s = win_data_s | (data[i*WORD_W +: WORD_W] & {WORD_W{win_s[i]}});
    end
  end

  assign hit_inc_s = hit_sat_inc(hit_q, det_in);

  // Next-state logic; every output is re-registered from its _d value.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    cur_id_d  = cur_id_q;
    last_d    = last_q;
    gnt_d     = {N_REQ{1'b0}};
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && (|req)) begin
          state_d  = ST_SHIFT;
          gnt_d    = win_s;
          shift_d  = win_data_s;
          cnt_d    = {CNT_W{1'b0}};
          hit_d    = {HIT_W{1'b0}};
          cur_id_d = win_idx_s;
          last_d   = win_idx_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        hit_d   = hit_inc_s;
        shift_d = {1'b0, shift_q[WORD_W-1:1]};
        if (cnt_q == CNT_W'(WORD_W - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        hit_d = hit_inc_s;
        if (cnt_q == CNT_W'(LAT - 1)) begin
          state_d   = ST_DONE;
          cnt_d     = {CNT_W{1'b0}};
          done_id_d = cur_id_q;
          hit_cnt_d = hit_inc_s;
        end else begin
          cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ser_d  = (state_d == ST_SHIFT) & shift_d[0];
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset also kills any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      shift_q   <= {WORD_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      hit_q     <= {HIT_W{1'b0}};
      cur_id_q  <= {IDX_W{1'b0}};
      last_q    <= IDX_W'(N_REQ - 1);
      gnt_q     <= {N_REQ{1'b0}};
      busy_q    <= 1'b0;
      ser_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {IDX_W{1'b0}};
      hit_cnt_q <= {HIT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      cur_id_q  <= cur_id_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      ser_q     <= ser_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign ser_out = ser_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_serial_stim_arbiter.sv
// Self-checking bench for serial_stim_arbiter with a "101" detector model
// (one cycle of output latency) in the feedback path.
module tb_serial_stim_arbiter;

  localparam int N = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           rstn, en;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy, ser_out, det_in, done;
  logic [1:0]     done_id;
  logic [3:0]     hit_cnt;

  logic           det_drv, det_src, det_model;
  logic [2:0]     hist;
  int             ncmp = 0;
  int             nerr = 0;
  int             cyc  = 0;
  int             wt, gc;

  serial_stim_arbiter #(.N_REQ(N), .WORD_W(W), .LAT(1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .req(req), .data(data), .gnt(gnt),
    .busy(busy), .ser_out(ser_out), .det_in(det_in), .done(done),
    .done_id(done_id), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign det_in = det_src ? det_model : det_drv;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist      <= 3'b000;
      det_model <= 1'b0;
    end else begin
      hist      <= {hist[1:0], ser_out};
      det_model <= ({hist[1:0], ser_out} == 3'b101);
    end
  end

  // Reference: a hit for every bit position closing a 1,0,1 run in the frame
  // (the line is idle-low before a frame), capped at 15.
  function automatic int ref_hits_det(input logic [W-1:0] w);
    int n = 0;
    for (int j = 2; j < W; j++) n += (w[j] && !w[j-1] && w[j-2]) ? 1 : 0;
    return (n > 15) ? 15 : n;
  endfunction

  // Reference: count det_in highs over the 14 SHIFT + 1 DRAIN cycles, capped.
  function automatic int ref_hits_mask(input logic [16:0] m);
    int n = 0;
    for (int k = 1; k <= 15; k++) n += m[k] ? 1 : 0;
    return (n > 15) ? 15 : n;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; req = '0; det_drv = 1'b0; det_src = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // mask[0]: det before grant / after frame, mask[1..15]: SHIFT+DRAIN cycles, mask[16]: DONE.
  task automatic run_frame(input int id, input logic [W-1:0] w, input logic [16:0] mask,
                           input bit drop_req, input bit drop_en,
                           output int waited, output int gcyc);
    int exp_h;
    int stray;
    exp_h  = det_src ? ref_hits_det(w) : ref_hits_mask(mask);
    waited = 0;
    stray  = 0;
    det_drv = mask[0];
    do begin
      @(negedge clk);
      waited++;
      if (done === 1'b1) stray++;
    end while (gnt === '0 && waited < 60);
    gcyc = cyc;
    ncmp++;
    if (gnt !== (4'b0001 << id)) begin
      nerr++; $display("FAIL grant: gnt=%b required %b (waited %0d)", gnt, 4'b0001 << id, waited);
    end
    ncmp++;
    if (stray !== 0) begin
      nerr++; $display("FAIL stray_done: %0d done pulses while waiting, required 0", stray);
    end
    for (int k = 1; k <= W; k++) begin
      if (k > 1) @(negedge clk);
      ncmp++;
      if (ser_out !== w[k-1]) begin
        nerr++; $display("FAIL ser_bit%0d: ser_out=%b required %b", k-1, ser_out, w[k-1]);
      end
      if (k == 2) begin
        ncmp++;
        if (gnt !== '0) begin
          nerr++; $display("FAIL gnt_pulse: gnt=%b required 0000", gnt);
        end
      end
      if (k == 1 && drop_req) req[id] = 1'b0;
      if (k == 3 && drop_en) en = 1'b0;
      det_drv = mask[k];
    end
    @(negedge clk);
    ncmp++;
    if (ser_out !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL drain: ser=%b done=%b busy=%b required 0 0 1", ser_out, done, busy);
    end
    det_drv = mask[15];
    @(negedge clk);
    ncmp++;
    if (done !== 1'b1 || done_id !== id[1:0] || hit_cnt !== exp_h[3:0]) begin
      nerr++; $display("FAIL done: done=%b id=%0d hits=%0d required 1 %0d %0d",
                       done, done_id, hit_cnt, id, exp_h);
    end
    det_drv = mask[16];
    @(negedge clk);
    ncmp++;
    if (done !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b0 ||
        done_id !== id[1:0] || hit_cnt !== exp_h[3:0]) begin
      nerr++; $display("FAIL idle_hold: done=%b busy=%b ser=%b id=%0d hits=%0d required 0 0 0 %0d %0d",
                       done, busy, ser_out, done_id, hit_cnt, id, exp_h);
    end
    det_drv = mask[0];
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; req = '0; det_drv = 1'b1; det_src = 1'b0; data = '0;
    #1;
    ncmp++; if (gnt !== '0) begin nerr++; $display("FAIL rst_gnt: %b required 0000", gnt); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: %b required 0", busy); end
    ncmp++; if (ser_out !== 1'b0) begin nerr++; $display("FAIL rst_ser: %b required 0", ser_out); end
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: %b required 0", done); end
    ncmp++; if (done_id !== 2'd0) begin nerr++; $display("FAIL rst_id: %0d required 0", done_id); end
    ncmp++; if (hit_cnt !== 4'd0) begin nerr++; $display("FAIL rst_hits: %0d required 0", hit_cnt); end
  endtask

  task automatic test_single_frame();
    do_reset();
    rand_data();
    data[0 +: W] = 14'h0007;
    en = 1'b1; req = 4'b0001;
    run_frame(0, 14'h0007, 17'd0, 1'b1, 1'b0, wt, gc);
    ncmp++; if (wt !== 1) begin nerr++; $display("FAIL first_grant_latency: %0d required 1", wt); end
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    do_reset();
    rand_data();
    en = 1'b1; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_frame(n % N, data[(n % N)*W +: W], 17'($urandom), 1'b0, 1'b0, wt, gc);
      if (n > 0) begin
        ncmp++;
        if (gc - prev !== 17) begin nerr++; $display("FAIL spacing%0d: %0d required 17", n, gc - prev); end
      end
      prev = gc;
    end
  endtask

  task automatic test_hits();
    logic [16:0] masks [4];
    masks[0] = 17'b0_0000_0000_0011_1000;
    masks[1] = 17'h1FFFF;
    masks[2] = 17'h10001;
    masks[3] = 17'($urandom);
    for (int t = 0; t < 4; t++) begin
      int id = $urandom_range(0, N-1);
      rand_data();
      en = 1'b1; req = 4'b0001 << id;
      run_frame(id, data[id*W +: W], masks[t], 1'b1, 1'b0, wt, gc);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    rand_data();
    data[0 +: W] = 14'h3FFF;
    en = 1'b1; req = 4'b0001; det_drv = 1'b1;
    wt = 0;
    do begin @(negedge clk); wt++; end while (gnt === '0 && wt < 40);
    repeat (4) @(negedge clk);
    ncmp++;
    if (busy !== 1'b1 || ser_out !== 1'b1) begin
      nerr++; $display("FAIL mid_precond: busy=%b ser=%b required 1 1", busy, ser_out);
    end
    #1 rstn = 1'b0; req = 4'b0010;
    #1;
    ncmp++;
    if (ser_out !== 1'b0 || gnt !== '0 || busy !== 1'b0 || hit_cnt !== 4'd0) begin
      nerr++; $display("FAIL async_rst: ser=%b gnt=%b busy=%b hits=%0d required 0 0000 0 0",
                       ser_out, gnt, busy, hit_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_frame(1, data[1*W +: W], 17'd0, 1'b1, 1'b0, wt, gc);
  endtask

  task automatic test_enable_gate();
    int bad = 0;
    rand_data();
    en = 1'b0; req = 4'b0100;
    repeat (20) begin
      @(negedge clk);
      if (gnt !== '0 || busy !== 1'b0 || ser_out !== 1'b0) bad++;
    end
    ncmp++; if (bad !== 0) begin nerr++; $display("FAIL en_block: %0d active cycles required 0", bad); end
    en = 1'b1;
    run_frame(2, data[2*W +: W], 17'($urandom), 1'b1, 1'b0, wt, gc);
    ncmp++; if (wt !== 1) begin nerr++; $display("FAIL en_latency: %0d required 1", wt); end
  endtask

  task automatic test_en_midframe();
    int id = $urandom_range(0, N-1);
    int bad = 0;
    rand_data();
    en = 1'b1; req = 4'b0001 << id;
    run_frame(id, data[id*W +: W], 17'($urandom), 1'b0, 1'b1, wt, gc);
    repeat (10) begin
      @(negedge clk);
      if (gnt !== '0) bad++;
    end
    ncmp++; if (bad !== 0) begin nerr++; $display("FAIL en_mid_block: %0d grants required 0", bad); end
    en = 1'b1;
    run_frame(id, data[id*W +: W], 17'd0, 1'b1, 1'b0, wt, gc);
  endtask

  task automatic test_round_robin_random();
    int mlast = N - 1;
    do_reset();
    en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [N-1:0] r;
      int exp_id = -1;
      r = N'($urandom_range(1, 15));
      for (int i = 1; i <= N; i++)
        if (exp_id < 0 && r[(mlast + i) % N]) exp_id = (mlast + i) % N;
      rand_data();
      req = r;
      run_frame(exp_id, data[exp_id*W +: W], 17'($urandom), 1'b0, 1'b0, wt, gc);
      mlast = exp_id;
    end
    req = '0;
  endtask

  task automatic test_detector_sweep();
    det_src = 1'b1;
    en = 1'b1;
    for (int v = 0; v <= 500; v += 7) begin
      int id = $urandom_range(0, N-1);
      logic [W-1:0] w;
      w = W'(v);
      rand_data();
      data[id*W +: W] = w;
      req = 4'b0001 << id;
      run_frame(id, w, 17'd0, 1'b1, 1'b0, wt, gc);
    end
    det_src = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hits();
    test_reset_midframe();
    test_enable_gate();
    test_en_midframe();
    test_round_robin_random();
    test_detector_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
